// File: rtl/sipo_pkg.sv
// Shared framing types and direction encodings for the serial-in/parallel-out register.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } sipo_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/sipo_frame_ctrl.sv
// Word framing for the shift register: fill state, bit counter, direction capture,
// word_valid and dir_err pulses. Priority is clear > par_load > load > hold.
//
// state | meaning
// IDLE  | no partial word, bit_count = 0
// FILL  | partial word, 0 < bit_count < WIDTH
// DONE  | full word in data_out this cycle (word_valid high)
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          par_load,
    input  logic          load,
    input  logic          dir,
    output logic [CW-1:0] bit_count,
    output logic          word_valid,
    output logic          dir_err
);

    sipo_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          derr_q, derr_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            derr_q  <= derr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        derr_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            dir_d   = DIR_LEFT;
        end else if (par_load) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (load) begin
            case (state_q)
                FILL: begin
                    // A direction flip mid-word restarts framing with this bit as bit 1.
                    if (dir != dir_q) begin
                        cnt_d  = CW'(1);
                        dir_d  = dir;
                        derr_d = 1'b1;
                    end else if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = CW'(1);
                    dir_d   = dir;
                end
            endcase
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    assign bit_count  = cnt_q;
    assign word_valid = (state_q == DONE);
    assign dir_err    = derr_q;

endmodule

// File: rtl/sipo_lr_param.sv
// Bidirectional serial-in/parallel-out shift register with parallel load, clear,
// and word framing supplied by sipo_frame_ctrl.
module sipo_lr_param
    import sipo_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dir,
    input  logic             data_in,
    input  logic             par_load,
    input  logic [WIDTH-1:0] par_in,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic [CW-1:0]    bit_count,
    output logic             word_valid,
    output logic             dir_err
);

    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = RST_VAL;
        end else if (par_load) begin
            data_d = par_in;
        end else if (load) begin
            if (dir == DIR_RIGHT) begin
                data_d = {data_in, data_q[WIDTH-1:1]};
            end else begin
                data_d = {data_q[WIDTH-2:0], data_in};
            end
        end
    end

    assign data_out   = data_q;
    assign serial_out = (dir == DIR_RIGHT) ? data_q[0] : data_q[WIDTH-1];

    sipo_frame_ctrl #(
        .WIDTH (WIDTH)
    ) u_frame (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .par_load   (par_load),
        .load       (load),
        .dir        (dir),
        .bit_count  (bit_count),
        .word_valid (word_valid),
        .dir_err    (dir_err)
    );

endmodule

// File: tb/tb_sipo_lr_param.sv
// Directed bench for sipo_lr_param at WIDTH=4, RST_VAL=0 with hand-computed expectations.
module tb_sipo_lr_param;

    logic       clock;
    logic       reset_n;
    logic       load;
    logic       dir;
    logic       data_in;
    logic       par_load;
    logic [3:0] par_in;
    logic       clear;
    logic [3:0] data_out;
    logic       serial_out;
    logic [2:0] bit_count;
    logic       word_valid;
    logic       dir_err;

    int n_assert = 0;
    int n_fail   = 0;

    sipo_lr_param #(
        .WIDTH   (4),
        .RST_VAL (4'b0000)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load),
        .dir        (dir),
        .data_in    (data_in),
        .par_load   (par_load),
        .par_in     (par_in),
        .clear      (clear),
        .data_out   (data_out),
        .serial_out (serial_out),
        .bit_count  (bit_count),
        .word_valid (word_valid),
        .dir_err    (dir_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs across one rising edge, then settle 1 time unit.
    task automatic step(input logic ld, input logic d, input logic bit_i,
                        input logic pl, input logic [3:0] pv, input logic clr);
        load     = ld;
        dir      = d;
        data_in  = bit_i;
        par_load = pl;
        par_in   = pv;
        clear    = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic [2:0] c,
                           input logic wv, input logic de);
        chk({tag, ".data"}, 32'(data_out), 32'(d));
        chk({tag, ".cnt"},  32'(bit_count), 32'(c));
        chk({tag, ".wv"},   32'(word_valid), 32'(wv));
        chk({tag, ".derr"}, 32'(dir_err), 32'(de));
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        #2 reset_n = 1'b1;
    endtask

    int wv_count;

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        dir      = 1'b0;
        data_in  = 1'b0;
        par_load = 1'b0;
        par_in   = 4'b0000;
        clear    = 1'b0;
        #3;
        chk_out("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
        #9 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Left shift, bits 1,0,1,1
        step(1, 0, 1, 0, 4'h0, 0); chk_out("left1", 4'b0001, 3'd1, 1'b0, 1'b0);
        step(1, 0, 0, 0, 4'h0, 0); chk_out("left2", 4'b0010, 3'd2, 1'b0, 1'b0);
        step(1, 0, 1, 0, 4'h0, 0); chk_out("left3", 4'b0101, 3'd3, 1'b0, 1'b0);
        step(1, 0, 1, 0, 4'h0, 0); chk_out("left4", 4'b1011, 3'd0, 1'b1, 1'b0);
        chk("left4.sout", 32'(serial_out), 32'd1);
        step(0, 0, 0, 0, 4'h0, 0); chk_out("hold", 4'b1011, 3'd0, 1'b0, 1'b0);

        pulse_reset();
        chk_out("rst2", 4'b0000, 3'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;

        // Right shift, bits 1,0,1,1
        step(1, 1, 1, 0, 4'h0, 0); chk_out("right1", 4'b1000, 3'd1, 1'b0, 1'b0);
        step(1, 1, 0, 0, 4'h0, 0); chk_out("right2", 4'b0100, 3'd2, 1'b0, 1'b0);
        step(1, 1, 1, 0, 4'h0, 0); chk_out("right3", 4'b1010, 3'd3, 1'b0, 1'b0);
        chk("right3.sout", 32'(serial_out), 32'd0);
        step(1, 1, 1, 0, 4'h0, 0); chk_out("right4", 4'b1101, 3'd0, 1'b1, 1'b0);
        chk("right4.sout", 32'(serial_out), 32'd1);

        // Clear, then a direction flip mid-word
        step(0, 0, 0, 0, 4'h0, 1); chk_out("clear", 4'b0000, 3'd0, 1'b0, 1'b0);
        step(1, 0, 1, 0, 4'h0, 0); chk_out("flipA", 4'b0001, 3'd1, 1'b0, 1'b0);
        step(1, 0, 1, 0, 4'h0, 0); chk_out("flipB", 4'b0011, 3'd2, 1'b0, 1'b0);
        step(1, 1, 0, 0, 4'h0, 0); chk_out("flipC", 4'b0001, 3'd1, 1'b0, 1'b1);
        step(1, 1, 1, 0, 4'h0, 0); chk_out("flipD", 4'b1000, 3'd2, 1'b0, 1'b0);
        step(1, 1, 1, 0, 4'h0, 0); chk_out("flipE", 4'b1100, 3'd3, 1'b0, 1'b0);
        step(1, 1, 1, 0, 4'h0, 0); chk_out("flipF", 4'b1110, 3'd0, 1'b1, 1'b0);

        // Parallel load wins over load; clear wins over parallel load
        step(1, 1, 1, 1, 4'b1010, 0); chk_out("pload", 4'b1010, 3'd0, 1'b0, 1'b0);
        chk("pload.sout_r", 32'(serial_out), 32'd0);
        dir = 1'b0;
        #1;
        chk("pload.sout_l", 32'(serial_out), 32'd1);
        step(1, 0, 1, 1, 4'b0110, 1); chk_out("clr_pri", 4'b0000, 3'd0, 1'b0, 1'b0);
        step(0, 0, 0, 1, 4'b1010, 0); chk_out("pload2", 4'b1010, 3'd0, 1'b0, 1'b0);

        // Eight continuous left-shift loads: bits 1,1,0,1,0,0,1,0
        wv_count = 0;
        step(1, 0, 1, 0, 4'h0, 0); chk_out("cont1", 4'b0101, 3'd1, 1'b0, 1'b0); wv_count += int'(word_valid);
        step(1, 0, 1, 0, 4'h0, 0); chk_out("cont2", 4'b1011, 3'd2, 1'b0, 1'b0); wv_count += int'(word_valid);
        step(1, 0, 0, 0, 4'h0, 0); chk_out("cont3", 4'b0110, 3'd3, 1'b0, 1'b0); wv_count += int'(word_valid);
        step(1, 0, 1, 0, 4'h0, 0); chk_out("cont4", 4'b1101, 3'd0, 1'b1, 1'b0); wv_count += int'(word_valid);
        step(1, 0, 0, 0, 4'h0, 0); chk_out("cont5", 4'b1010, 3'd1, 1'b0, 1'b0); wv_count += int'(word_valid);
        step(1, 0, 0, 0, 4'h0, 0); chk_out("cont6", 4'b0100, 3'd2, 1'b0, 1'b0); wv_count += int'(word_valid);
        step(1, 0, 1, 0, 4'h0, 0); chk_out("cont7", 4'b1001, 3'd3, 1'b0, 1'b0); wv_count += int'(word_valid);
        step(1, 0, 0, 0, 4'h0, 0); chk_out("cont8", 4'b0010, 3'd0, 1'b1, 1'b0); wv_count += int'(word_valid);
        chk("cont.wv_count", 32'(wv_count), 32'd2);

        // Direction change while in DONE: no dir_err, new word starts
        step(1, 1, 1, 0, 4'h0, 0); chk_out("done_dir", 4'b1001, 3'd1, 1'b0, 1'b0);
        step(1, 1, 0, 0, 4'h0, 0); chk_out("pre_rst", 4'b0100, 3'd2, 1'b0, 1'b0);

        // Asynchronous reset mid-word
        #2 reset_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 3'd0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        step(0, 0, 0, 0, 4'h0, 0); chk_out("post_rst1", 4'b0000, 3'd0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 4'h0, 0); chk_out("post_rst2", 4'b0000, 3'd0, 1'b0, 1'b0);

        // Direction change with load low does not raise dir_err
        step(1, 0, 1, 0, 4'h0, 0); chk_out("idle_dirA", 4'b0001, 3'd1, 1'b0, 1'b0);
        step(0, 1, 0, 0, 4'h0, 0); chk_out("idle_dirB", 4'b0001, 3'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_lr_param.md
SIPO_LR_PARAM -- requirements
Module: sipo_lr_param

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter RST_VAL, default all-zeros, value of data_out after reset or clear.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port load  input  1  serial shift enable; one bit is accepted per clock while high.
REQ-006 Port dir  input  1  shift direction: 0 = left (enter at LSB), 1 = right (enter at MSB).
REQ-007 Port data_in  input  1  serial data bit.
REQ-008 Port par_load  input  1  parallel load strobe.
REQ-009 Port par_in  input  WIDTH  parallel load value.
REQ-010 Port clear  input  1  synchronous clear of register and framing.
REQ-011 Port data_out  output  WIDTH  register contents.
REQ-012 Port serial_out  output  1  bit being shifted out: data_out[WIDTH-1] when dir=0, data_out[0] when dir=1 (combinational).
REQ-013 Port bit_count  output  $clog2(WIDTH+1)  serial bits accepted in the current word.
REQ-014 Port word_valid  output  1  one-cycle pulse: a full WIDTH-bit serial word is in data_out.
REQ-015 Port dir_err  output  1  one-cycle pulse: dir changed while a word was partially filled.

Function
REQ-016 Priority per edge SHALL be clear > par_load > load > hold.
REQ-017 clear SHALL set data_out=RST_VAL, bit_count=0, state IDLE, with no word_valid and no dir_err.
REQ-018 par_load SHALL set data_out=par_in, bit_count=0, state IDLE, with no word_valid; a simultaneous load is ignored.
REQ-019 load with dir=0 SHALL set data_out <= {data_out[WIDTH-2:0], data_in}.
REQ-020 load with dir=1 SHALL set data_out <= {data_in, data_out[WIDTH-1:1]}.
REQ-021 With load, par_load and clear all low, data_out, bit_count and state SHALL hold.
REQ-022 FSM states SHALL be IDLE (bit_count=0), FILL (0<bit_count<WIDTH) and DONE.
REQ-023 IDLE + load -> FILL, bit_count=1.
REQ-024 FILL + load with bit_count=WIDTH-1 -> DONE, bit_count=0, word_valid=1 in the cycle data_out first holds the complete word (zero latency after the WIDTH-th shifting edge).
REQ-025 FILL + load with bit_count<WIDTH-1 -> FILL, bit_count+1.
REQ-026 DONE SHALL last one cycle; with load -> FILL, bit_count=1 (back-to-back words, no gap); without load -> IDLE.
REQ-027 word_valid SHALL be registered and high only in DONE.
REQ-028 In FILL, a load edge whose dir differs from the dir of the previous accepted bit SHALL still shift, restart the word with bit_count=1, and pulse dir_err for one cycle.
REQ-029 A dir change in IDLE or DONE, or with load low, SHALL NOT raise dir_err; the direction is captured on the next accepted bit.
REQ-030 bit_count SHALL never exceed WIDTH-1 and SHALL wrap to 0 only through DONE, clear or par_load.

Reset
REQ-031 reset_n low SHALL asynchronously force data_out=RST_VAL, bit_count=0, state IDLE, word_valid=0, dir_err=0 and the captured direction=0.
REQ-032 Reset assertion mid-word SHALL discard the partial word; deassertion SHALL take effect on the next rising edge with no spurious pulse.

Structure
REQ-033 A shared package sipo_pkg SHALL hold the FSM state enum (IDLE, FILL, DONE) and direction constants DIR_LEFT=0 and DIR_RIGHT=1.
REQ-034 Framing SHALL live in one sub-module, sipo_frame_ctrl (FSM, bit_count, direction capture, pulses); the datapath stays in sipo_lr_param.

Verification (WIDTH=4, RST_VAL=0)
REQ-035 Reset, then dir=0, load=1 with bits 1,0,1,1 -> data_out 0001,0010,0101,1011; word_valid=1 only with 1011.
REQ-036 Reset, then dir=1, load=1 with bits 1,0,1,1 -> data_out 1000,0100,1010,1101; word_valid=1 only with 1101.
REQ-037 dir=0, two bits 1,1, then dir=1 with bit 0 -> data_out=0001, dir_err pulse, bit_count=1; no word_valid until 3 more bits.
REQ-038 par_load=1 with par_in=1010 and load=1 -> data_out=1010, bit_count=0; with dir=1, serial_out=0.
REQ-039 Eight continuous load cycles -> exactly two word_valid pulses, on the 4th and 8th edges.
REQ-040 reset_n low between edges after 2 bits -> data_out=0000 immediately, bit_count=0, no word_valid after release.
